// File: rtl/div32_seq_pkg.sv
// div32_seq_pkg: shared divider defines (state encodings, default width, counter width).
// Contents:
//   W_DEF   - default divisor/quotient/remainder width
//   CNT_W   - iteration counter width (covers ITER up to 64)
//   state_t - divider FSM states, 2-bit encoding
package div32_seq_pkg;

    localparam int W_DEF = 32;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/div32_seq_step.sv
// div_step: one combinational restoring shift-subtract-select step.
// Ports:
//   rem     - partial remainder, always < d on entry
//   bit_in  - next dividend bit shifted into the remainder
//   d       - divisor magnitude
//   rem_nxt - partial remainder after the step
//   q_bit   - quotient bit produced by this step
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem,
    input  logic         bit_in,
    input  logic [W-1:0] d,
    output logic [W-1:0] rem_nxt,
    output logic         q_bit
);

    logic [W:0]   sh;
    logic [W-1:0] diff;

    assign sh      = {rem, bit_in};
    // Trial subtract over W+1 bits: non-negative exactly when sh >= d.
    assign q_bit   = sh >= {1'b0, d};
    // sh < 2*d, so a successful difference always fits in W bits.
    assign diff    = sh[W-1:0] - d;
    assign rem_nxt = q_bit ? diff : sh[W-1:0];

endmodule

// File: rtl/div32_seq.sv
// div32_seq: sequential restoring divider implementing x86 DIV/IDIV r/m32 (EDX:EAX / src).
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_valid, in_ready    - request handshake (ready only in IDLE)
//   dividend, divisor     - 2W-bit EDX:EAX and W-bit r/m operand, sampled on accept
//   is_signed             - 1 = IDIV, 0 = DIV
//   flush                 - abort any operation, back to IDLE at next edge
//   out_valid, out_ready  - result handshake (valid only in DONE)
//   quotient, remainder   - EAX / EDX results, zero outside DONE
//   de                    - divide error (zero divisor or quotient overflow)
module div32_seq
    import div32_seq_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int ITER = W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    input  logic           is_signed,
    input  logic           flush,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           de
);

    state_t           state, nxt;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     rem, lo, dvs, q_out, r_out;
    logic             neg_q, neg_r, sgn, de_r;
    logic [2*W-1:0]   n2_in, n2, dd_mag;
    logic [W-1:0]     nw_in, nw, dv_mag, rem_nxt, q_fix, r_fix;
    logic             dd_neg, dv_neg, div_err, accept, q_bit, ovf;

    // One negate path per width: operands on accept, quotient/remainder in FIXUP.
    assign nw_in   = (state == FIXUP) ? lo : divisor;
    assign n2_in   = (state == FIXUP) ? {{W{1'b0}}, rem} : dividend;
    assign nw      = ~nw_in + W'(1);
    assign n2      = ~n2_in + (2*W)'(1);

    assign dd_neg  = is_signed & dividend[2*W-1];
    assign dv_neg  = is_signed & divisor[W-1];
    assign dd_mag  = dd_neg ? n2 : dividend;
    assign dv_mag  = dv_neg ? nw : divisor;
    // Upper half >= divisor means the magnitude quotient needs more than W bits.
    assign div_err = (dv_mag == '0) | (dd_mag[2*W-1:W] >= dv_mag);

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign accept    = in_valid & in_ready & ~flush;
    assign quotient  = out_valid ? q_out : '0;
    assign remainder = out_valid ? r_out : '0;
    assign de        = out_valid & de_r;

    // After ITER steps lo holds the quotient magnitude and rem the remainder magnitude.
    assign q_fix = neg_q ? nw : lo;
    assign r_fix = neg_r ? n2[W-1:0] : rem;
    // Signed range: positive up to 2^(W-1)-1, negative down to -2^(W-1).
    assign ovf   = neg_q ? (lo[W-1] & |lo[W-2:0]) : (sgn & lo[W-1]);

    div_step #(.W(W)) u_step (
        .rem     (rem),
        .bit_in  (lo[W-1]),
        .d       (dvs),
        .rem_nxt (rem_nxt),
        .q_bit   (q_bit)
    );

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = in_valid ? (div_err ? DONE : BUSY) : IDLE;
            BUSY:    nxt = (cnt == CNT_W'(ITER - 1)) ? FIXUP : BUSY;
            FIXUP:   nxt = DONE;
            DONE:    nxt = out_ready ? IDLE : DONE;
            default: nxt = IDLE;
        endcase
        if (flush) nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            rem   <= '0;
            lo    <= '0;
            dvs   <= '0;
            q_out <= '0;
            r_out <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            sgn   <= 1'b0;
            de_r  <= 1'b0;
        end else begin
            state <= nxt;
            if (accept) begin
                rem   <= dd_mag[2*W-1:W];
                lo    <= dd_mag[W-1:0];
                dvs   <= dv_mag;
                cnt   <= '0;
                neg_q <= dd_neg ^ dv_neg;
                neg_r <= dd_neg;
                sgn   <= is_signed;
                de_r  <= div_err;
                q_out <= '0;
                r_out <= '0;
            end else if (state == BUSY) begin
                rem <= rem_nxt;
                lo  <= {lo[W-2:0], q_bit};
                cnt <= cnt + CNT_W'(1);
            end else if (state == FIXUP) begin
                de_r  <= ovf;
                q_out <= ovf ? '0 : q_fix;
                r_out <= ovf ? '0 : r_fix;
            end
        end
    end

endmodule

// File: doc/div32_seq.md
DIV32_SEQ -- requirements
Module: div32_seq

Interface
REQ-001 The module SHALL have parameter W, default 32, meaning the divisor, quotient and remainder width; the dividend is 2*W.
REQ-002 The module SHALL have parameter ITER, default W, meaning the number of restoring iterations.
REQ-003 The module SHALL have port clk, input, 1, the only clock; all flops update on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 The module SHALL have port in_valid, input, 1, meaning a request is present.
REQ-006 The module SHALL have port in_ready, output, 1, meaning the unit can accept a request.
REQ-007 The module SHALL have port dividend, input, 2W, meaning the EDX:EAX operand, sampled on accept.
REQ-008 The module SHALL have port divisor, input, W, meaning the r/m32 operand, sampled on accept.
REQ-009 The module SHALL have port is_signed, input, 1: 1=IDIV, 0=DIV; sampled on accept.
REQ-010 The module SHALL have port flush, input, 1, meaning abort any in-flight operation.
REQ-011 The module SHALL have port out_valid, output, 1, meaning the result is present.
REQ-012 The module SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-013 The module SHALL have port quotient, output, W, meaning the EAX result.
REQ-014 The module SHALL have port remainder, output, W, meaning the EDX result.
REQ-015 The module SHALL have port de, output, 1, meaning divide-error (#DE) for zero divisor or quotient overflow.

Function
REQ-016 The module SHALL implement states IDLE, BUSY, FIXUP and DONE; in_ready SHALL equal 1 only in IDLE; out_valid SHALL equal 1 only in DONE.
REQ-017 Accept SHALL occur when in_valid&in_ready at a clock edge; operands SHALL be latched and sign magnitudes formed (|dividend| over 2W bits, |divisor| over W bits; unsigned mode passes operands through).
REQ-018 On accept, if divisor==0, or the upper W bits of |dividend| are >= |divisor|, the FSM SHALL go to DONE with de=1 and quotient=remainder=0; out_valid SHALL be high the cycle after accept.
REQ-019 Otherwise the FSM SHALL go to BUSY; each BUSY cycle SHALL perform one restoring step: shift the partial remainder left 1, bring in the next dividend bit, do a W+1-bit trial subtract, and set the quotient bit to 1 if the result is non-negative, restoring otherwise.
REQ-020 An iteration counter SHALL count 0..ITER-1; at count ITER-1 the FSM SHALL go to FIXUP.
REQ-021 In FIXUP: q SHALL be negated if the dividend and divisor signs differ (signed only); r SHALL take the dividend's sign (signed only).
REQ-022 Signed quotient overflow in FIXUP SHALL set de=1 and zero the outputs: positive q with magnitude > 2^(W-1)-1, or negative q with magnitude > 2^(W-1).
REQ-023 FIXUP SHALL go to DONE; out_valid SHALL assert exactly ITER+2 cycles after the accept edge (34 for W=32).
REQ-024 DONE SHALL hold quotient, remainder and de stable while out_ready=0; on out_ready=1 the FSM SHALL go to IDLE, and a new accept is possible the following cycle (no same-cycle pass-through).
REQ-025 flush=1 SHALL force IDLE at the next edge from any state, discarding the result; flush has priority over accept and over out_ready.
REQ-026 Outputs outside DONE SHALL be 0 (quotient, remainder, de).

Reset
REQ-027 Asserting rst_n=0 SHALL immediately set the state to IDLE, the counter to 0, all operand/result registers to 0, in_ready=1, out_valid=0 and de=0, including mid-BUSY; deassertion SHALL take effect synchronously to clk.

Structure
REQ-028 The state encodings (2 bits: IDLE=0, BUSY=1, FIXUP=2, DONE=3), the W default and the counter width SHALL live in the shared divider defines package, for reuse by the decode/exception logic.
REQ-029 The module SHALL contain one sub-module, div_step, a combinational W+1-bit shift-subtract-select step instantiated once and iterated in time.
REQ-030 The negation logic (operand magnitude and fixup) SHALL reuse one shared two's-complement negate path per operand width; no multiplier or divider operators SHALL be used.

Verification
REQ-031 The bench SHALL cover: unsigned 0x00000000_00000064 / 7 -> q=0x0000000E, r=2, de=0, out_valid 34 cycles after accept.
REQ-032 The bench SHALL cover: signed 0xFFFFFFFF_FFFFFF9C / 7 -> q=0xFFFFFFF2, r=0xFFFFFFFE, de=0.
REQ-033 The bench SHALL cover: divisor=0, and unsigned 0x00000005_00000000 / 5 -> de=1, q=r=0, out_valid the cycle after accept.
REQ-034 The bench SHALL cover: signed 0xFFFFFFFF_80000000 / 0xFFFFFFFF -> de=1 at FIXUP; signed 0xFFFFFFFF_80000000 / 1 -> q=0x80000000, de=0.
REQ-035 The bench SHALL cover: hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0; then out_ready=1 -> IDLE, and back-to-back accepts give correct results.
REQ-036 The bench SHALL cover: flush at BUSY iteration 5, and rst_n=0 at iteration 20 -> IDLE, out_valid never asserted, and the next request completes correctly.
